pipelined_dual_port_blockram: RTL and testbench
===============================================

PIPELINED_DUAL_PORT_BLOCKRAM -- requirements
Module: pipelined_dual_port_blockram

Interface
REQ-001 SHALL have parameter SINGLE_ELEMENT_SIZE_IN_BITS, default 64, element width; must be a multiple of 8.
REQ-002 SHALL have parameter NUMBER_SET, default 64, number of sets (depth).
REQ-003 SHALL have parameter SET_PTR_WIDTH_IN_BITS, default 6, address width; equals clog2(NUMBER_SET).
REQ-004 SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter WRITE_FIRST, default 1, same-address collision mode: 1 = new data, 0 = old data.
REQ-006 SHALL have parameter INIT_VALUE, default 0, value swept into every set after reset.
REQ-007 SHALL have the following ports, all synchronous to one clock; reset is asynchronous and active-low:
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- ready_out  output  1  high when initialisation is complete and requests are accepted.
- read_en_in  input  1  read request.
- read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read address.
- read_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read data.
- read_valid_out  output  1  one-cycle pulse qualifying read_element_out.
- write_en_in  input  1  write request.
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address.
- write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- write_byte_en_in  input  SINGLE_ELEMENT_SIZE_IN_BITS/8  per-byte write mask.
- evict_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  prior content of the written set.
- evict_valid_out  output  1  one-cycle pulse qualifying evict_element_out.

Function
REQ-008 SHALL implement two states: INIT and READY.
- INIT is entered on reset.
- In INIT, one set is written with INIT_VALUE per cycle, address counter 0 to NUMBER_SET-1.
- After the write to set NUMBER_SET-1, the block SHALL move to READY; ready_out goes high on the following edge.
REQ-009 SHALL ignore read_en_in and write_en_in while ready_out is 0; no valid pulses, no memory change.
REQ-010 SHALL sample an accepted read at the rising edge; read_element_out and read_valid_out=1 appear exactly READ_LATENCY cycles later.
REQ-011 SHALL hold read_element_out at its last value when no read completes; read_valid_out=0 in those cycles.
REQ-012 SHALL write on the rising edge:
- bytes with write_byte_en_in=1 are updated;
- bytes with write_byte_en_in=0 are preserved;
- a write with an all-zero mask leaves memory unchanged but still produces an eviction.
REQ-013 SHALL present the full pre-write content of the written set on evict_element_out, with evict_valid_out=1, one cycle after the write edge.
REQ-014 SHALL resolve a same-address, same-edge read and write as follows:
- WRITE_FIRST=1: return the byte-merged new data.
- WRITE_FIRST=0: return the old data.
REQ-015 SHALL support back-to-back reads and writes every cycle with no bubbles; the pipeline is fully pipelined for READ_LATENCY=2.
REQ-016 SHALL drop writes to addresses >= NUMBER_SET with no eviction pulse; reads from such addresses return INIT_VALUE with a valid pulse.

Reset
REQ-017 SHALL, on reset_in=0, asynchronously force:
- state to INIT and the init counter to 0;
- ready_out, read_valid_out and evict_valid_out to 0;
- read_element_out and evict_element_out to 0.
REQ-018 SHALL discard in-flight reads and evictions on reset mid-operation; memory is cleared only by the INIT sweep, not by the reset itself.

Structure
REQ-019 SHALL place the INIT/READY state encodings and the default width/depth constants in the shared parameters.h.
REQ-020 SHALL implement the INIT sweep (FSM plus address counter) as the sub-module blockram_init_sequencer; the storage array and pipeline registers stay in the top level.

Verification
REQ-021 SHALL verify reset and init: release reset, hold all requests -> ready_out=0 for 64 cycles, then 1; a read of set 63 returns 0.
REQ-022 SHALL verify write-then-read: write 0xFFFFFFFF00000000 to set 63 with mask 0xFF, read set 63 -> READ_LATENCY=1 data 0xFFFFFFFF00000000 with a one-cycle valid pulse.
REQ-023 SHALL verify byte mask: set 62 holds 0x0000000000000000; write 0xFFFFFFFFFFFFFFFF with mask 0x0F -> read returns 0x00000000FFFFFFFF.
REQ-024 SHALL verify eviction: write 0x00000000FFFFFFFF, then 0xFFFFFFFF00000000, to set 61 -> second write yields evict 0x00000000FFFFFFFF with a single-cycle evict_valid_out.
REQ-025 SHALL verify collision: set 60 holds 0xAA..AA; same-edge write of 0x55..55 and read of set 60 -> WRITE_FIRST=1 returns 0x55..55; WRITE_FIRST=0 returns 0xAA..AA.
REQ-026 SHALL verify reset mid-operation: assert reset_in=0 one cycle after a READ_LATENCY=2 read -> no valid pulse appears; ready_out drops immediately and the INIT sweep repeats.

Source files
------------

// File: rtl/pipelined_dual_port_blockram_pkg.sv
// Shared types and default sizing for the pipelined dual-port block RAM.
// Holds the init/ready state encodings used by the sweep sequencer.
package pipelined_dual_port_blockram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_t;

    localparam int DEFAULT_ELEMENT_BITS = 64;
    localparam int DEFAULT_NUMBER_SET   = 64;
    localparam int DEFAULT_SET_PTR_BITS = 6;
    localparam int DEFAULT_READ_LATENCY = 1;

endpackage

// File: rtl/blockram_init_sequencer.sv
// Post-reset sweep: walks every set once, then reports ready.
// Ready is a pure decode of the state register.
module blockram_init_sequencer
    import pipelined_dual_port_blockram_pkg::*;
#(
    parameter int NUMBER_SET            = DEFAULT_NUMBER_SET,
    parameter int SET_PTR_WIDTH_IN_BITS = DEFAULT_SET_PTR_BITS
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    output logic                             init_we,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0] init_addr,
    output logic                             ready
);

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
        SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1);

    init_state_t                      state_q;
    init_state_t                      state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] cnt_q;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] cnt_d;

    // State and sweep-counter registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one set per cycle, leave INIT after the last one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we   = 1'b0;
        init_addr = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (cnt_q == LAST_SET) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign ready = (state_q == ST_READY);

endmodule

// File: rtl/pipelined_dual_port_blockram.sv
// Dual-port block RAM with byte-masked writes, eviction output,
// 1- or 2-cycle read pipeline and post-reset init sweep.
module pipelined_dual_port_blockram
    import pipelined_dual_port_blockram_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_BITS,
    parameter int NUMBER_SET                  = DEFAULT_NUMBER_SET,
    parameter int SET_PTR_WIDTH_IN_BITS       = DEFAULT_SET_PTR_BITS,
    parameter int READ_LATENCY                = DEFAULT_READ_LATENCY,
    parameter int WRITE_FIRST                 = 1,
    parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    output logic                                   ready_out,
    input  logic                                   read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out,
    output logic                                   read_valid_out,
    input  logic                                   write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS/8-1:0] write_byte_en_in,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_out,
    output logic                                   evict_valid_out
);

    localparam int W     = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int BYTES = W / 8;
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] DEPTH =
        (SET_PTR_WIDTH_IN_BITS + 1)'(NUMBER_SET);

    logic [W-1:0] mem [NUMBER_SET];

    logic                             ready;
    logic                             init_we;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] init_addr;

    logic         rd_in_range;
    logic         wr_in_range;
    logic         rd_accept;
    logic         wr_accept;
    logic [W-1:0] wr_old;
    logic [W-1:0] wr_merged;
    logic [W-1:0] rd_word;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic         ev_valid;
    logic [W-1:0] ev_data;

    blockram_init_sequencer #(
        .NUMBER_SET            (NUMBER_SET),
        .SET_PTR_WIDTH_IN_BITS (SET_PTR_WIDTH_IN_BITS)
    ) u_init_seq (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    assign ready_out   = ready;
    assign rd_in_range = {1'b0, read_set_addr_in} < DEPTH;
    assign wr_in_range = {1'b0, write_set_addr_in} < DEPTH;
    assign rd_accept   = ready && read_en_in;
    assign wr_accept   = ready && write_en_in && wr_in_range;
    assign wr_old      = mem[write_set_addr_in];

    // Byte-merge the incoming element over the current content.
    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < BYTES; i++) begin
            if (write_byte_en_in[i]) begin
                wr_merged[8*i +: 8] = write_element_in[8*i +: 8];
            end
        end
    end

    // Read word, with write-first bypass on a same-set collision.
    always_comb begin
        rd_word = INIT_VALUE;
        if (rd_in_range) begin
            rd_word = mem[read_set_addr_in];
        end
        if (WRITE_FIRST != 0 && wr_accept &&
            write_set_addr_in == read_set_addr_in) begin
            rd_word = wr_merged;
        end
    end

    // Storage: init sweep has priority; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VALUE;
        end else if (wr_accept) begin
            mem[write_set_addr_in] <= wr_merged;
        end
    end

    // First read stage; data only moves on an accepted read.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    // Eviction capture of the pre-write content.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ev_valid <= 1'b0;
            ev_data  <= '0;
        end else begin
            ev_valid <= wr_accept;
            if (wr_accept) begin
                ev_data <= wr_old;
            end
        end
    end

    assign evict_valid_out   = ev_valid;
    assign evict_element_out = ev_data;

    if (READ_LATENCY == 2) begin : g_lat2
        logic         s2_valid;
        logic [W-1:0] s2_data;

        // Second read stage, holding data between completions.
        always_ff @(posedge clk_in or negedge reset_in) begin
            if (!reset_in) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign read_valid_out   = s2_valid;
        assign read_element_out = s2_data;
    end else begin : g_lat1
        assign read_valid_out   = s1_valid;
        assign read_element_out = s1_data;
    end

endmodule

// File: tb/tb_pipelined_dual_port_blockram.sv
// Bench: two instances (64 sets/L1/write-first, 62 sets/L2/read-first)
// driven with shared stimulus and checked against an array model.
module tb_pipelined_dual_port_blockram;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  raddr = '0;
    logic [5:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;

    logic        o_rdy [2];
    logic        o_rv  [2];
    logic        o_ev  [2];
    logic [63:0] o_rd  [2];
    logic [63:0] o_ed  [2];

    always #5 clk = ~clk;

    pipelined_dual_port_blockram dut0 (
        .clk_in            (clk),
        .reset_in          (reset_in),
        .ready_out         (o_rdy[0]),
        .read_en_in        (re),
        .read_set_addr_in  (raddr),
        .read_element_out  (o_rd[0]),
        .read_valid_out    (o_rv[0]),
        .write_en_in       (we),
        .write_set_addr_in (waddr),
        .write_element_in  (wdata),
        .write_byte_en_in  (be),
        .evict_element_out (o_ed[0]),
        .evict_valid_out   (o_ev[0])
    );

    pipelined_dual_port_blockram #(
        .NUMBER_SET   (62),
        .READ_LATENCY (2),
        .WRITE_FIRST  (0),
        .INIT_VALUE   (64'h0123_4567_89AB_CDEF)
    ) dut1 (
        .clk_in            (clk),
        .reset_in          (reset_in),
        .ready_out         (o_rdy[1]),
        .read_en_in        (re),
        .read_set_addr_in  (raddr),
        .read_element_out  (o_rd[1]),
        .read_valid_out    (o_rv[1]),
        .write_en_in       (we),
        .write_set_addr_in (waddr),
        .write_element_in  (wdata),
        .write_byte_en_in  (be),
        .evict_element_out (o_ed[1]),
        .evict_valid_out   (o_ev[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          nsets [2] = '{64, 62};
    int          lat   [2] = '{1, 2};
    bit          wf    [2] = '{1'b1, 1'b0};
    logic [63:0] initv [2] = '{64'h0, 64'h0123_4567_89AB_CDEF};

    logic [63:0] mm    [2][64];
    int          ncyc  [2];
    logic        e_rdy [2];
    logic        e_rv  [2];
    logic        e_ev  [2];
    logic [63:0] e_rd  [2];
    logic [63:0] e_ed  [2];
    int          cyc = 0;

    typedef struct {
        int          k;
        int          due;
        logic [63:0] d;
    } rd_t;
    rd_t pend [$];

    typedef struct {
        logic        we;
        logic [5:0]  waddr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        re;
        logic [5:0]  raddr;
        logic        rv;
        logic [63:0] rd;
        logic        ev;
        logic [63:0] ed;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), 64'(o_rdy[k]), 64'(e_rdy[k]));
            chk($sformatf("rvalid%0d", k), 64'(o_rv[k]), 64'(e_rv[k]));
            chk($sformatf("rdata%0d", k), o_rd[k], e_rd[k]);
            chk($sformatf("evalid%0d", k), 64'(o_ev[k]), 64'(e_ev[k]));
            chk($sformatf("edata%0d", k), o_ed[k], e_ed[k]);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            ncyc[k]  = 0;
            e_rdy[k] = 1'b0;
            e_rv[k]  = 1'b0;
            e_ev[k]  = 1'b0;
            e_rd[k]  = '0;
            e_ed[k]  = '0;
        end
    endtask

    // Effect of one clock edge on instance k, from pre-edge inputs.
    task automatic model_edge(input int k);
        logic [63:0] d;
        logic [63:0] old;
        logic [63:0] mrg;
        bit          wacc;
        e_rv[k] = 1'b0;
        e_ev[k] = 1'b0;
        if (ncyc[k] >= nsets[k]) begin
            wacc = we && (int'(waddr) < nsets[k]);
            old  = wacc ? mm[k][waddr] : 64'h0;
            mrg  = old;
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mrg[8*b +: 8] = wdata[8*b +: 8];
            end
            if (re) begin
                d = (int'(raddr) < nsets[k]) ? mm[k][raddr] : initv[k];
                if (wf[k] && wacc && raddr == waddr) d = mrg;
                pend.push_back('{k, cyc + lat[k], d});
            end
            if (wacc) begin
                e_ev[k] = 1'b1;
                e_ed[k] = old;
                mm[k][waddr] = mrg;
            end
        end
        ncyc[k]++;
        if (ncyc[k] == nsets[k]) begin
            for (int a = 0; a < 64; a++) mm[k][a] = initv[k];
        end
        e_rdy[k] = (ncyc[k] >= nsets[k]);
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        cyc++;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == cyc) begin
                e_rv[pend[i].k] = 1'b1;
                e_rd[pend[i].k] = pend[i].d;
                pend.delete(i);
            end
        end
        @(negedge clk);
        cmp_all();
    endtask

    task automatic idle();
        re = 1'b0;
        we = 1'b0;
        be = '0;
    endtask

    task automatic rand_in();
        re    = 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        raddr = 6'($urandom_range(0, 63));
        waddr = ($urandom_range(0, 3) == 0) ? raddr
                                            : 6'($urandom_range(0, 63));
        wdata = {$urandom(), $urandom()};
        be    = 8'($urandom());
    endtask

    initial begin
        tbl[0]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd63,
                    1'b1, 64'h0, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b0, 6'd0,
                    1'b0, 64'h0, 1'b0, 64'h0};
        tbl[2]  = '{1'b1, 6'd63, 64'hFFFF_FFFF_0000_0000, 8'hFF, 1'b0, 6'd0,
                    1'b0, 64'h0, 1'b1, 64'h0};
        tbl[3]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd63,
                    1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, 64'h0};
        tbl[4]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b0, 6'd0,
                    1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0, 64'h0};
        tbl[5]  = '{1'b1, 6'd62, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 6'd0,
                    1'b0, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'h0};
        tbl[6]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd62,
                    1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 6'd61, 64'h0000_0000_FFFF_FFFF, 8'hFF, 1'b0, 6'd0,
                    1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'h0};
        tbl[8]  = '{1'b1, 6'd61, 64'hFFFF_FFFF_0000_0000, 8'hFF, 1'b0, 6'd0,
                    1'b0, 64'h0000_0000_FFFF_FFFF,
                    1'b1, 64'h0000_0000_FFFF_FFFF};
        tbl[9]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b0, 6'd0,
                    1'b0, 64'h0000_0000_FFFF_FFFF,
                    1'b0, 64'h0000_0000_FFFF_FFFF};
        tbl[10] = '{1'b1, 6'd60, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 6'd0,
                    1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'h0};
        tbl[11] = '{1'b1, 6'd60, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 6'd60,
                    1'b1, 64'h5555_5555_5555_5555,
                    1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[12] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd60,
                    1'b1, 64'h5555_5555_5555_5555,
                    1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[13] = '{1'b1, 6'd59, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 6'd0,
                    1'b0, 64'h5555_5555_5555_5555, 1'b1, 64'h0};
        tbl[14] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd59,
                    1'b1, 64'h0, 1'b0, 64'h0};

        #2 reset_in = 1'b0;
        model_reset();
        #1 cmp_all();
        @(posedge clk);
        @(negedge clk);
        reset_in = 1'b1;

        // Init sweep with all requests held low.
        for (int i = 0; i < 66; i++) tick();

        // Directed vectors checked against the instance with 64 sets.
        for (int i = 0; i < 15; i++) begin
            we    = tbl[i].we;
            waddr = tbl[i].waddr;
            wdata = tbl[i].wdata;
            be    = tbl[i].be;
            re    = tbl[i].re;
            raddr = tbl[i].raddr;
            tick();
            chk($sformatf("tbl_rv[%0d]", i), 64'(o_rv[0]), 64'(tbl[i].rv));
            chk($sformatf("tbl_rd[%0d]", i), o_rd[0], tbl[i].rd);
            chk($sformatf("tbl_ev[%0d]", i), 64'(o_ev[0]), 64'(tbl[i].ev));
            chk($sformatf("tbl_ed[%0d]", i), o_ed[0], tbl[i].ed);
        end
        idle();
        tick();

        // Collision on set 10: write-first vs read-first instance.
        we = 1'b1; waddr = 6'd10; wdata = 64'hAAAA_AAAA_AAAA_AAAA; be = 8'hFF;
        tick();
        wdata = 64'h5555_5555_5555_5555;
        re = 1'b1; raddr = 6'd10;
        tick();
        chk("coll_wf1", o_rd[0], 64'h5555_5555_5555_5555);
        idle();
        tick();
        chk("coll_wf0_v", 64'(o_rv[1]), 64'h1);
        chk("coll_wf0", o_rd[1], 64'hAAAA_AAAA_AAAA_AAAA);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rand_in();
            tick();
        end

        // Reset one cycle after a read, while it is still in flight.
        idle();
        re = 1'b1; raddr = 6'd5;
        tick();
        idle();
        reset_in = 1'b0;
        model_reset();
        #1 cmp_all();
        chk("rst_rv_l2", 64'(o_rv[1]), 64'h0);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            @(posedge clk);
            @(negedge clk);
            cmp_all();
        end
        reset_in = 1'b1;

        // Repeat sweep with requests that must be ignored, then traffic.
        for (int i = 0; i < 66; i++) begin
            rand_in();
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            rand_in();
            tick();
        end
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
